// File: rtl/hi_lo_mac.sv
// Sequential 32x32 signed multiply / multiply-accumulate unit with HI/LO registers.
// One radix-2 shift-add step per cycle on magnitudes; sign and accumulate applied in ACC.
module hi_lo_mac #(
  parameter int ITER = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done
);

  localparam logic [4:0] OP_MULT = 5'b00011;
  localparam logic [4:0] OP_MADD = 5'b00100;
  localparam logic [4:0] OP_MSUB = 5'b00101;
  localparam logic [4:0] OP_MTHI = 5'b11100;
  localparam logic [4:0] OP_MTLO = 5'b11101;
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t          state, state_nxt;
  logic [4:0]      op_q;
  logic            neg_q;
  logic [63:0]     mcand_q;
  logic [31:0]     mplier_q;
  logic [63:0]     acc_q;
  logic [CW-1:0]   cnt_q;

  logic            is_mul;
  logic [31:0]     a_mag, b_mag;
  logic [63:0]     prod, hilo, res;

  assign is_mul = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign Busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start && is_mul) state_nxt = MUL;
      MUL:     if (cnt_q == CW'(ITER - 1)) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;
    hilo = {HI, LO};
    case (op_q)
      OP_MADD: res = hilo + prod;
      OP_MSUB: res = hilo - prod;
      default: res = prod;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      HI       <= '0;
      LO       <= '0;
      Done     <= 1'b0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      Done <= (state == ACC);
      case (state)
        IDLE: begin
          if (Start) begin
            if (Op == OP_MTHI) HI <= A;
            if (Op == OP_MTLO) LO <= A;
            if (is_mul) begin
              op_q     <= Op;
              neg_q    <= A[31] ^ B[31];
              mcand_q  <= {32'd0, a_mag};
              mplier_q <= b_mag;
              acc_q    <= '0;
              cnt_q    <= '0;
            end
          end
        end
        MUL: begin
          // multiplicand walks left while the multiplier walks right
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 64'd0);
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 1'b1;
        end
        ACC: begin
          {HI, LO} <= res;
          cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_mac.sv
// Scoreboard bench for hi_lo_mac: expected {HI,LO} pushed at issue, popped on Done.
module tb_hi_lo_mac;

  localparam logic [4:0] OP_MULT = 5'b00011;
  localparam logic [4:0] OP_MADD = 5'b00100;
  localparam logic [4:0] OP_MSUB = 5'b00101;
  localparam logic [4:0] OP_MTHI = 5'b11100;
  localparam logic [4:0] OP_MTLO = 5'b11101;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [4:0]  Op;
  logic [31:0] A, B, HI, LO;
  logic        Busy, Done;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mhi = '0, mlo = '0;

  hi_lo_mac #(.ITER(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Called at a negedge while idle; returns at the following negedge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, e;
    Start = 1'b1; Op = op; A = a; B = b;
    if (op == OP_MULT || op == OP_MADD || op == OP_MSUB) begin
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      if (op == OP_MULT)      e = p;
      else if (op == OP_MADD) e = {mhi, mlo} + p;
      else                    e = {mhi, mlo} - p;
      sb_q.push_back(e);
      {mhi, mlo} = e;
    end else if (op == OP_MTHI) mhi = a;
    else if (op == OP_MTLO)     mlo = a;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input bit scramble, input string nm);
    int n = 0;
    bit got = 0;
    logic [63:0] e;
    for (int i = 0; i < 100; i++) begin
      if (Done === 1'b1) begin got = 1; Start = 1'b0; break; end
      if (Busy === 1'b1) n++;
      if (scramble) begin
        Start = 1'($urandom_range(0, 1)); Op = 5'($urandom); A = $urandom; B = $urandom;
        // last busy cycle: a Start lands on the Done edge and must be dropped
        if (n == 33) begin Start = 1'b1; Op = OP_MULT; end
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL %s done_timeout busy_cycles=%0d", nm, n); return; end
    checks++;
    if (n != 33) begin errors++; $display("FAIL %s busy_cycles got %0d want 33", nm, n); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL %s scoreboard_empty", nm); return; end
    e = sb_q.pop_front();
    checks++;
    if ({HI, LO} !== e) begin errors++; $display("FAIL %s hilo got %h want %h", nm, {HI, LO}, e); end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || {HI, LO} !== e) begin
      errors++;
      $display("FAIL %s after_done done=%b busy=%b hilo=%h want 0 0 %h", nm, Done, Busy, {HI, LO}, e);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
    #23;
    checks++;
    if (HI !== '0 || LO !== '0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset hi=%h lo=%h busy=%b done=%b want zeros", HI, LO, Busy, Done);
    end
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_move;
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h1);
    checks++;
    if (HI !== 32'hDEAD_BEEF || LO !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL mthi hi=%h lo=%h busy=%b done=%b want deadbeef 0 0 0", HI, LO, Busy, Done);
    end
    issue(OP_MTLO, 32'h1234_5678, 32'h0);
    checks++;
    if (HI !== 32'hDEAD_BEEF || LO !== 32'h1234_5678 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL mtlo hi=%h lo=%h busy=%b done=%b want deadbeef 12345678 0 0", HI, LO, Busy, Done);
    end
  endtask

  task automatic test_mult;
    issue(OP_MULT, 32'd6, 32'd7);
    wait_done(0, "mult_6x7");
    checks++;
    if (HI !== 32'h0 || LO !== 32'h2A) begin errors++; $display("FAIL mult_6x7_const got %h_%h want 0_2a", HI, LO); end
    issue(OP_MULT, 32'd2000000000, 32'd7);
    wait_done(0, "mult_big");
    checks++;
    if (HI !== 32'h3 || LO !== 32'h4277_0C00) begin errors++; $display("FAIL mult_big_const got %h_%h want 3_42770c00", HI, LO); end
    issue(OP_MULT, 32'd2000000000, -32'sd7);
    wait_done(0, "mult_bigneg");
    checks++;
    if (HI !== 32'hFFFF_FFFC || LO !== 32'hBD88_F400) begin errors++; $display("FAIL mult_bigneg_const got %h_%h want fffffffc_bd88f400", HI, LO); end
  endtask

  task automatic test_madd_msub;
    logic [31:0] bb [4] = '{32'd4, -32'sd4, 32'd4, -32'sd4};
    logic [4:0]  oo [4] = '{OP_MADD, OP_MADD, OP_MSUB, OP_MSUB};
    logic [63:0] ee [4] = '{{32'd12, 32'd13}, {32'd11, 32'hFFFF_FFF5},
                            {32'd11, 32'hFFFF_FFF5}, {32'd12, 32'd13}};
    for (int i = 0; i < 4; i++) begin
      issue(OP_MTHI, 32'd12, 32'd0);
      issue(OP_MTLO, 32'd1, 32'd0);
      issue(oo[i], 32'd3, bb[i]);
      wait_done(0, "acc");
      checks++;
      if ({HI, LO} !== ee[i]) begin errors++; $display("FAIL acc_const%0d got %h want %h", i, {HI, LO}, ee[i]); end
    end
  endtask

  task automatic test_boundary;
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(0, "min_sq");
    checks++;
    if (HI !== 32'h4000_0000 || LO !== 32'h0) begin errors++; $display("FAIL min_sq_const got %h_%h want 40000000_0", HI, LO); end
    issue(OP_MTHI, 32'h5555_5555, 32'd0);
    issue(OP_MULT, 32'h0, 32'h8000_0000);
    wait_done(0, "zero_a");
    checks++;
    if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL zero_a_const got %h want 0", {HI, LO}); end
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, "neg1_sq");
    issue(OP_MADD, 32'h7FFF_FFFF, 32'h0);
    wait_done(0, "madd_zero_b");
    issue(OP_MSUB, 32'h8000_0000, 32'h7FFF_FFFF);
    wait_done(0, "msub_extreme");
  endtask

  task automatic test_back_to_back;
    logic [4:0] ops [3] = '{OP_MULT, OP_MADD, OP_MSUB};
    for (int i = 0; i < 6; i++) begin
      issue(ops[$urandom_range(0, 2)], $urandom, $urandom);
      wait_done(1, "b2b_scrambled");
    end
  endtask

  task automatic test_bad_op;
    issue(5'b00000, 32'hFFFF_0000, 32'h1234);
    checks++;
    if (Busy !== 1'b0 || {HI, LO} !== {mhi, mlo}) begin
      errors++; $display("FAIL bad_op busy=%b hilo=%h want 0 %h", Busy, {HI, LO}, {mhi, mlo});
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL bad_op_later done=%b busy=%b want 0 0", Done, Busy); end
  endtask

  task automatic test_abort;
    int dn = 0;
    issue(OP_MTHI, 32'h55, 32'h0);
    issue(OP_MTLO, 32'hAA, 32'h0);
    issue(OP_MULT, 32'd6, 32'd7);
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = OP_MULT; A = 32'd2; B = 32'd2;
    @(negedge Clk); Start = 1'b0;
    repeat (14) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (HI !== '0 || LO !== '0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL abort_async hi=%h lo=%h busy=%b done=%b want zeros", HI, LO, Busy, Done);
    end
    sb_q.delete(); mhi = '0; mlo = '0;
    @(negedge Clk); Reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) dn++;
    end
    checks++;
    if (dn != 0 || {HI, LO} !== 64'h0) begin errors++; $display("FAIL abort_quiet activity=%0d hilo=%h want 0 0", dn, {HI, LO}); end
  endtask

  task automatic test_reset_release;
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    issue(OP_MULT, 32'd9, -32'sd9);
    wait_done(0, "first_after_reset");
  endtask

  initial begin
    test_reset();
    test_move();
    test_mult();
    test_madd_msub();
    test_boundary();
    test_back_to_back();
    test_bad_op();
    test_abort();
    test_reset_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
